// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words from imem over req/ack,
// holds each instruction for decode and steps the PC when it is consumed.
module instr_fetch_unit #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]      HALT_OP  = 6'h3F
) (
    input  logic              In_Clk,
    input  logic              In_Rst_n,
    input  logic              In_Enable,
    output logic              Out_IMemReq,
    output logic [ADDR_W-1:0] Out_IMemAddr,
    input  logic              In_IMemAck,
    input  logic [31:0]       In_IMemData,
    output logic [31:0]       Out_Instr,
    output logic [5:0]        Out_Opcode,
    output logic              Out_InstrValid,
    input  logic              In_InstrTake,
    input  logic              In_PCSrc,
    input  logic              In_JumpPC,
    output logic [ADDR_W-1:0] Out_PC,
    output logic              Out_Halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic              req;
    logic              valid;
    logic              halted;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] next_pc;

    // Next PC on consume; a jump overrides a taken branch
    always_comb begin
        pc_inc = pc + ADDR_W'(1);
        br_off = ADDR_W'({{16{instr[15]}}, instr[15:0]});
        if (In_JumpPC) begin
            next_pc = instr[ADDR_W-1:0];
        end else if (In_PCSrc) begin
            next_pc = pc_inc + br_off;
        end else begin
            next_pc = pc_inc;
        end
    end

    // Sequencer with registered req/valid/halted outputs
    always_ff @(posedge In_Clk or negedge In_Rst_n) begin
        if (!In_Rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            instr  <= '0;
            req    <= 1'b0;
            valid  <= 1'b0;
            halted <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (In_Enable) begin
                        state <= FETCH;
                        req   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (In_IMemAck) begin
                        instr <= In_IMemData;
                        state <= ISSUE;
                        req   <= 1'b0;
                        valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (In_InstrTake) begin
                        pc    <= next_pc;
                        valid <= 1'b0;
                        if (instr[31:26] == HALT_OP) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (In_Enable) begin
                            state <= FETCH;
                            req   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HALT: begin
                    if (!In_Enable) begin
                        state  <= IDLE;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign Out_IMemReq    = req;
    assign Out_IMemAddr   = pc;
    assign Out_PC         = pc;
    assign Out_Instr      = instr;
    assign Out_Opcode     = instr[31:26];
    assign Out_InstrValid = valid;
    assign Out_Halted     = halted;

endmodule
